sram_secded_bridge: RTL and testbench

- Sits directly downstream of the SoC core's SRAM port (SRAMCS0/SRAMWEN/SRAMADDR/SRAMWDATA/SRAMRDATA) and drives a 39-bit-wide single-port synchronous SRAM macro.
- Adds SECDED (39,32) Hsiao protection: encodes on write, corrects single-bit and flags double-bit errors on read.
- Converts partial byte writes into read-modify-write, with a one-cycle stall signalled on SRAMREADY.

---
 rtl/sram_secded_bridge_pkg.sv | 33 +++
 rtl/sram_secded_bridge_dec.sv | 30 +++
 rtl/sram_secded_bridge.sv | 157 +++++++++++++++
 tb/tb_sram_secded_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_secded_bridge_pkg.sv
// Shared SECDED (39,32) Hsiao definitions for the SRAM bridge and its bench:
// data/check widths, H-matrix data columns, bridge FSM states and the encoder.
package sram_secded_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;
  localparam int CODE_W = DATA_W + CHK_W;

  // Data-bit columns of H: the first 32 weight-3 values in ascending order.
  // Check-bit columns are the unit vectors, so every column has odd weight.
  localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  // Check bits: XOR of the H columns of every set data bit.
  function automatic logic [CHK_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ H_COL[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/sram_secded_bridge_dec.sv
// Combinational SECDED (39,32) decoder: syndrome, single-bit correction and
// error classification. Check-bit-only errors are correctable and leave data.
module secded_39_32_dec
  import sram_secded_bridge_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              corr,
  output logic              uncorr
);

  logic [CHK_W-1:0] syn;
  logic             hit;

  // Syndrome, column match and correction.
  always_comb begin
    syn  = code[CODE_W-1:DATA_W] ^ ecc_encode(code[DATA_W-1:0]);
    data = code[DATA_W-1:0];
    hit  = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      if (syn == H_COL[j]) begin
        data[j] = ~code[j];
        hit     = 1'b1;
      end
    end
    corr   = (syn != '0) && (hit || $onehot(syn));
    uncorr = (syn != '0) && !corr;
  end

endmodule

// File: rtl/sram_secded_bridge.sv
// SoC SRAM port to 39-bit SECDED-protected SRAM macro bridge.
// Full writes are encoded directly; partial writes become a read-modify-write
// with one stall cycle (MERGE). Optional correctable-error scrubbing is built
// when the macro SRAM_SCRUB_EN is defined.
module sram_secded_bridge
  import sram_secded_bridge_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               SRAMCS0,
  input  logic [3:0]         SRAMWEN,
  input  logic [ADDR_W-1:0]  SRAMADDR,
  input  logic [DATA_W-1:0]  SRAMWDATA,
  output logic [DATA_W-1:0]  SRAMRDATA,
  output logic               SRAMREADY,
  output logic               MEM_EN,
  output logic               MEM_WE,
  output logic [ADDR_W-1:0]  MEM_A,
  output logic [CODE_W-1:0]  MEM_DI,
  input  logic [CODE_W-1:0]  MEM_DO,
  output logic               ERR_CORR,
  output logic               ERR_UNCORR,
  output logic [ADDR_W-1:0]  ERR_ADDR
);

  state_t              state, state_nxt;
  logic                accept, is_rd;
  logic                rd_vld_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [3:0]          wen_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [DATA_W-1:0]   dec_data;
  logic                dec_corr, dec_uncorr;
  logic                consume;
  logic [DATA_W-1:0]   merged;

  assign accept  = (state == ST_IDLE) && SRAMCS0 && !HRESET;
  assign is_rd   = (SRAMWEN == 4'h0);
  assign consume = rd_vld_p1 || (state == ST_MERGE);

`ifdef SRAM_SCRUB_EN
  logic                scrub_vld;
  logic [ADDR_W-1:0]   scrub_addr;
  logic [DATA_W-1:0]   scrub_data;
  logic                scrub_wr, scrub_load, scrub_cancel;

  // Any write to the pending location supersedes the scrub; a write to the
  // location being reported this cycle makes the corrected copy stale.
  assign scrub_cancel = scrub_vld && accept && !is_rd && (SRAMADDR == scrub_addr);
  assign scrub_load   = rd_vld_p1 && dec_corr && !scrub_vld &&
                        !(accept && !is_rd && (SRAMADDR == addr_p1));

  // Scrub-pending flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                      scrub_vld <= 1'b0;
    else if (scrub_wr || scrub_cancel) scrub_vld <= 1'b0;
    else if (scrub_load)             scrub_vld <= 1'b1;
  end

  // Scrub payload: address and corrected word.
  always_ff @(posedge HCLK) begin
    if (scrub_load) begin
      scrub_addr <= addr_p1;
      scrub_data <= dec_data;
    end
  end
`endif

  secded_39_32_dec u_dec (
    .code   (MEM_DO),
    .data   (dec_data),
    .corr   (dec_corr),
    .uncorr (dec_uncorr)
  );

  // Byte merge of captured write data over the corrected old word.
  always_comb begin
    merged = dec_data;
    for (int b = 0; b < 4; b++) begin
      if (wen_p1[b]) merged[8*b +: 8] = wdata_p1[8*b +: 8];
    end
  end

  // Next state and macro control.
  always_comb begin
    state_nxt = state;
    SRAMREADY = 1'b1;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_A     = SRAMADDR;
    MEM_DI    = {ecc_encode(SRAMWDATA), SRAMWDATA};
`ifdef SRAM_SCRUB_EN
    scrub_wr  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          MEM_EN = 1'b1;
          MEM_WE = (SRAMWEN == 4'hF);
          if (!is_rd && (SRAMWEN != 4'hF)) state_nxt = ST_MERGE;
        end
`ifdef SRAM_SCRUB_EN
        else if (!HRESET && scrub_vld) begin
          MEM_EN   = 1'b1;
          MEM_WE   = 1'b1;
          MEM_A    = scrub_addr;
          MEM_DI   = {ecc_encode(scrub_data), scrub_data};
          scrub_wr = 1'b1;
        end
`endif
      end
      ST_MERGE: begin
        SRAMREADY = 1'b0;
        MEM_A     = addr_p1;
        MEM_DI    = {ecc_encode(merged), merged};
        MEM_EN    = !dec_uncorr;
        MEM_WE    = !dec_uncorr;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SRAMRDATA  = rd_vld_p1 ? dec_data : rdata_q;
  assign ERR_CORR   = consume && dec_corr;
  assign ERR_UNCORR = consume && dec_uncorr;
  assign ERR_ADDR   = (ERR_CORR || ERR_UNCORR) ? addr_p1 : err_addr_q;

  // Stage p0 -> p1: state, read-valid, held read data and error address.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      rd_vld_p1  <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= accept && is_rd;
      if (rd_vld_p1) rdata_q <= dec_data;
      if (ERR_CORR || ERR_UNCORR) err_addr_q <= addr_p1;
    end
  end

  // Stage p0 -> p1: captured request fields for read completion and merge.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_p1  <= SRAMADDR;
      wen_p1   <= SRAMWEN;
      wdata_p1 <= SRAMWDATA;
    end
  end

endmodule

// File: tb/tb_sram_secded_bridge.sv
// Self-checking bench for sram_secded_bridge with a behavioural 39-bit macro,
// a read scoreboard and fault injection on the macro read path.
module tb_sram_secded_bridge;
  import sram_secded_bridge_pkg::*;

  localparam int AW = 12;

  logic              clk, rst;
  logic              cs0;
  logic [3:0]        wen;
  logic [AW-1:0]     addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_a;
  logic [38:0]       mem_di, mem_do;
  logic              err_corr, err_uncorr;
  logic [AW-1:0]     err_addr;

  typedef struct {
    logic [31:0]   data;
    logic          corr;
    logic          uncorr;
    logic [AW-1:0] a;
  } exp_t;

  exp_t        exp_q[$];
  logic [38:0] mem [0:(1<<AW)-1];
  logic [38:0] flip_mask;
  logic        rd_acc;
  int          we_cnt;
  int          n_reads;
  int          n_tests;
  int          n_fail;

  sram_secded_bridge #(.ADDR_W(AW)) dut (
    .HCLK(clk), .HRESET(rst), .SRAMCS0(cs0), .SRAMWEN(wen), .SRAMADDR(addr),
    .SRAMWDATA(wdata), .SRAMRDATA(rdata), .SRAMREADY(ready), .MEM_EN(mem_en),
    .MEM_WE(mem_we), .MEM_A(mem_a), .MEM_DI(mem_di), .MEM_DO(mem_do),
    .ERR_CORR(err_corr), .ERR_UNCORR(err_uncorr), .ERR_ADDR(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Macro model: registered read with injectable bit flips.
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_a] <= mem_di;
      else        mem_do     <= mem[mem_a] ^ flip_mask;
    end
  end
  always @(posedge clk) if (mem_en && mem_we) we_cnt <= we_cnt + 1;

  // Read scoreboard.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_acc <= 1'b0;
    else     rd_acc <= cs0 && (wen == 4'h0) && ready;
  end
  always @(negedge clk) begin
    if (rd_acc) begin
      if (exp_q.size() == 0) check_eq("rd_unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rdata", rdata, e.data);
        check_eq("err_corr", err_corr, e.corr);
        check_eq("err_uncorr", err_uncorr, e.uncorr);
        if (e.corr || e.uncorr) check_eq("err_addr", err_addr, e.a);
        n_reads++;
      end
    end
  end

  task automatic drive(input logic c, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
    cs0 = c; wen = w; addr = a; wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    drive(1'b1, 4'hF, a, d);
    step();
    drive(1'b0, 4'h0, '0, '0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] d, input logic c, input logic u);
    exp_t e;
    e.data = d; e.corr = c; e.uncorr = u; e.a = a;
    exp_q.push_back(e);
    drive(1'b1, 4'h0, a, '0);
    step();
    drive(1'b0, 4'h0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    logic [31:0] bb [0:15];
    logic [31:0] w;
    n_tests = 0; n_fail = 0; we_cnt = 0; n_reads = 0;
    flip_mask = '0;
    rst = 1'b1;
    drive(1'b0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_err_corr", err_corr, 0);
    check_eq("rst_err_uncorr", err_uncorr, 0);
    check_eq("rst_err_addr", err_addr, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b0;
    step();

    // Full write and read back.
    drive(1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("fw_en", mem_en, 1);
    check_eq("fw_we", mem_we, 1);
    check_eq("fw_a", mem_a, 12'h010);
    check_eq("fw_di", mem_di, {ecc_encode(32'hDEADBEEF), 32'hDEADBEEF});
    check_eq("fw_ready", ready, 1);
    step();
    drive(1'b0, 4'h0, '0, '0);
    do_read(12'h010, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    check_eq("rdata_hold", rdata, 32'hDEADBEEF);

    // Partial write read-modify-write.
    do_write(12'h020, 32'h11223344);
    wc0 = we_cnt;
    drive(1'b1, 4'b0101, 12'h020, 32'hAABBCCDD);
    @(negedge clk);
    check_eq("pw_n_ready", ready, 1);
    check_eq("pw_n_en", mem_en, 1);
    check_eq("pw_n_we", mem_we, 0);
    step();
    drive(1'b1, 4'hF, 12'h030, 32'h00000055);
    @(negedge clk);
    check_eq("pw_m_ready", ready, 0);
    check_eq("pw_m_we", mem_we, 1);
    check_eq("pw_m_a", mem_a, 12'h020);
    check_eq("pw_m_di", mem_di, {ecc_encode(32'h11BB33DD), 32'h11BB33DD});
    step();
    drive(1'b0, 4'h0, '0, '0);
    @(negedge clk);
    check_eq("pw_after_ready", ready, 1);
    check_eq("pw_mem", mem[12'h020], {ecc_encode(32'h11BB33DD), 32'h11BB33DD});
    check_eq("pw_ignored", mem[12'h030], 39'h0);
    check_eq("pw_we_cnt", we_cnt, wc0 + 1);
    step();
    do_read(12'h020, 32'h11BB33DD, 1'b0, 1'b0);
    step();

    // Single-bit error on read.
    do_write(12'h040, 32'h12345678);
    flip_mask = 39'h1 << 5;
    wc0 = we_cnt;
    do_read(12'h040, 32'h12345678, 1'b1, 1'b0);
    flip_mask = '0;
    step();
    @(negedge clk);
    check_eq("sbe_pulse_end", err_corr, 0);
    check_eq("sbe_err_addr_hold", err_addr, 12'h040);
`ifdef SRAM_SCRUB_EN
    check_eq("scrub_we", mem_we, 1);
    check_eq("scrub_a", mem_a, 12'h040);
    check_eq("scrub_di", mem_di, {ecc_encode(32'h12345678), 32'h12345678});
    step();
    check_eq("scrub_we_cnt", we_cnt, wc0 + 1);
`else
    check_eq("noscrub_en", mem_en, 0);
    step();
    check_eq("noscrub_we_cnt", we_cnt, wc0);
`endif
    check_eq("sbe_mem", mem[12'h040], {ecc_encode(32'h12345678), 32'h12345678});

    // Double-bit error on read, then during a partial write.
    do_write(12'h050, 32'hCAFEF00D);
    flip_mask = (39'h1 << 3) | (39'h1 << 17);
    do_read(12'h050, 32'hCAFEF00D ^ 32'h00020008, 1'b0, 1'b1);
    step();
    wc0 = we_cnt;
    drive(1'b1, 4'b0001, 12'h050, 32'h000000FF);
    step();
    drive(1'b0, 4'h0, '0, '0);
    @(negedge clk);
    check_eq("dbe_m_ready", ready, 0);
    check_eq("dbe_m_en", mem_en, 0);
    check_eq("dbe_m_we", mem_we, 0);
    check_eq("dbe_m_uncorr", err_uncorr, 1);
    check_eq("dbe_m_err_addr", err_addr, 12'h050);
    step();
    flip_mask = '0;
    check_eq("dbe_we_cnt", we_cnt, wc0);
    check_eq("dbe_mem", mem[12'h050], {ecc_encode(32'hCAFEF00D), 32'hCAFEF00D});
    do_read(12'h050, 32'hCAFEF00D, 1'b0, 1'b0);
    step();

    // Reset asserted during MERGE.
    wc0 = we_cnt;
    drive(1'b1, 4'b0011, 12'h060, 32'h1234ABCD);
    step();
    drive(1'b0, 4'h0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rm_ready", ready, 1);
    check_eq("rm_en", mem_en, 0);
    check_eq("rm_we", mem_we, 0);
    check_eq("rm_err_corr", err_corr, 0);
    check_eq("rm_err_uncorr", err_uncorr, 0);
    check_eq("rm_err_addr", err_addr, 0);
    check_eq("rm_rdata", rdata, 0);
    step();
    step();
    check_eq("rm_we_cnt", we_cnt, wc0);
    check_eq("rm_mem", mem[12'h060], 39'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    do_read(12'h010, 32'hDEADBEEF, 1'b0, 1'b0);
    step();

    // Back-to-back reads of addresses 0..15.
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      bb[i] = w;
      do_write(i[AW-1:0], w);
    end
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.data = bb[i]; e.corr = 1'b0; e.uncorr = 1'b0; e.a = i[AW-1:0];
      exp_q.push_back(e);
      drive(1'b1, 4'h0, i[AW-1:0], '0);
      @(negedge clk);
      check_eq("b2b_ready", ready, 1);
      step();
    end
    drive(1'b0, 4'h0, '0, '0);
    step();
    step();
    check_eq("reads_total", n_reads, 22);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
